// File: rtl/fp_cmp_pipe_if.sv
// Handshake and operand/result bundle for fp_cmp_pipe.
// nan_cnt exists only when FP_CMP_NAN_EN is defined.
interface fp_cmp_pipe_if #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 9
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         lt;
  logic         gt;
  logic         eq;
  logic         unord;
`ifdef FP_CMP_NAN_EN
  logic [7:0]   nan_cnt;

  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, lt, gt, eq, unord, nan_cnt
  );
  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, lt, gt, eq, unord, nan_cnt
  );
`else
  modport master (
    output in_valid, a, b, opcode, out_ready,
    input  in_ready, out_valid, result, lt, gt, eq, unord
  );
  modport slave (
    input  in_valid, a, b, opcode, out_ready,
    output in_ready, out_valid, result, lt, gt, eq, unord
  );
`endif
endinterface

// File: rtl/fp_cmp_pipe.sv
// Two-stage floating-point compare/min/max pipeline with valid/ready flow control.
// Optional NaN handling and nan_cnt output enabled by macro FP_CMP_NAN_EN.
module fp_cmp_pipe #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 9
) (
  input logic          clk,
  input logic          rst,
  fp_cmp_pipe_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;

  typedef enum logic [2:0] {
    OP_LT   = 3'b000,
    OP_GT   = 3'b001,
    OP_EQ   = 3'b010,
    OP_LE   = 3'b011,
    OP_GE   = 3'b100,
    OP_MIN  = 3'b101,
    OP_MAX  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  // Stage 1 state
  logic         s1_valid_q, s1_valid_d;
  logic [W-1:0] s1_a_q, s1_a_d;
  logic [W-1:0] s1_b_q, s1_b_d;
  op_e          s1_op_q, s1_op_d;
  logic         s1_lt_q, s1_lt_d;
  logic         s1_gt_q, s1_gt_d;
  logic         s1_eq_q, s1_eq_d;
  logic         s1_unord_q, s1_unord_d;
  logic         s1_a_nan_q, s1_a_nan_d;
  logic         s1_b_nan_q, s1_b_nan_d;

  // Stage 2 (output) state
  logic         s2_valid_q, s2_valid_d;
  logic [W-1:0] res_q, res_d;
  logic         lt_q, lt_d;
  logic         gt_q, gt_d;
  logic         eq_q, eq_d;
  logic         unord_q, unord_d;

  logic s1_load, s2_load;
  logic a_nan, b_nan, a_zero, b_zero, c_lt, c_gt, c_eq;
  logic [W-1:0] res_sel;
  logic         rel;

  assign s2_load      = !s2_valid_q || bus.out_ready;
  assign s1_load      = !s1_valid_q || s2_load;
  assign bus.in_ready = s1_load;

  // Classification and sign-magnitude relation of the incoming pair
  always_comb begin
    a_nan = 1'b0;
    b_nan = 1'b0;
`ifdef FP_CMP_NAN_EN
    a_nan = (&bus.a[W-2:MAN_W]) && (|bus.a[MAN_W-1:0]);
    b_nan = (&bus.b[W-2:MAN_W]) && (|bus.b[MAN_W-1:0]);
`endif
    a_zero = (bus.a[W-2:0] == '0);
    b_zero = (bus.b[W-2:0] == '0);
    c_lt = 1'b0;
    c_gt = 1'b0;
    c_eq = 1'b0;
    if (a_nan || b_nan) begin
      c_lt = 1'b0;
    end else if (a_zero && b_zero) begin
      c_eq = 1'b1;
    end else if (bus.a[W-1] != bus.b[W-1]) begin
      c_lt = bus.a[W-1];
      c_gt = bus.b[W-1];
    end else if (bus.a[W-2:0] == bus.b[W-2:0]) begin
      c_eq = 1'b1;
    end else begin
      // Magnitude order flips when both operands are negative
      c_lt = (bus.a[W-2:0] < bus.b[W-2:0]) ^ bus.a[W-1];
      c_gt = !c_lt;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s1_lt_d    = s1_lt_q;
    s1_gt_d    = s1_gt_q;
    s1_eq_d    = s1_eq_q;
    s1_unord_d = s1_unord_q;
    s1_a_nan_d = s1_a_nan_q;
    s1_b_nan_d = s1_b_nan_q;
    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      s1_a_d     = bus.a;
      s1_b_d     = bus.b;
      s1_op_d    = op_e'(bus.opcode);
      s1_lt_d    = c_lt;
      s1_gt_d    = c_gt;
      s1_eq_d    = c_eq;
      s1_unord_d = a_nan || b_nan;
      s1_a_nan_d = a_nan;
      s1_b_nan_d = b_nan;
    end
  end

  // Opcode decode and result select
  always_comb begin
    rel     = 1'b0;
    res_sel = '0;
    case (s1_op_q)
      OP_LT: rel = s1_lt_q;
      OP_GT: rel = s1_gt_q;
      OP_EQ: rel = s1_eq_q;
      OP_LE: rel = s1_lt_q || s1_eq_q;
      OP_GE: rel = s1_gt_q || s1_eq_q;
      default: rel = 1'b0;
    endcase
    case (s1_op_q)
      OP_LT, OP_GT, OP_EQ, OP_LE, OP_GE: res_sel = rel ? '1 : '0;
      OP_MIN: begin
        if (s1_unord_q) res_sel = (s1_a_nan_q && !s1_b_nan_q) ? s1_b_q : s1_a_q;
        else            res_sel = (s1_lt_q || s1_eq_q) ? s1_a_q : s1_b_q;
      end
      OP_MAX: begin
        if (s1_unord_q) res_sel = (s1_a_nan_q && !s1_b_nan_q) ? s1_b_q : s1_a_q;
        else            res_sel = (s1_gt_q || s1_eq_q) ? s1_a_q : s1_b_q;
      end
      default: res_sel = '0;
    endcase
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    res_d      = res_q;
    lt_d       = lt_q;
    gt_d       = gt_q;
    eq_d       = eq_q;
    unord_d    = unord_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d   = res_sel;
        lt_d    = s1_lt_q;
        gt_d    = s1_gt_q;
        eq_d    = s1_eq_q;
        unord_d = s1_unord_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= OP_LT;
      s1_lt_q    <= 1'b0;
      s1_gt_q    <= 1'b0;
      s1_eq_q    <= 1'b0;
      s1_unord_q <= 1'b0;
      s1_a_nan_q <= 1'b0;
      s1_b_nan_q <= 1'b0;
      s2_valid_q <= 1'b0;
      res_q      <= '0;
      lt_q       <= 1'b0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      unord_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s1_lt_q    <= s1_lt_d;
      s1_gt_q    <= s1_gt_d;
      s1_eq_q    <= s1_eq_d;
      s1_unord_q <= s1_unord_d;
      s1_a_nan_q <= s1_a_nan_d;
      s1_b_nan_q <= s1_b_nan_d;
      s2_valid_q <= s2_valid_d;
      res_q      <= res_d;
      lt_q       <= lt_d;
      gt_q       <= gt_d;
      eq_q       <= eq_d;
      unord_q    <= unord_d;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.result    = res_q;
  assign bus.lt        = lt_q;
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;
  assign bus.unord     = unord_q;

`ifdef FP_CMP_NAN_EN
  logic [7:0] nan_cnt_q, nan_cnt_d;

  always_comb begin
    nan_cnt_d = nan_cnt_q;
    if (s2_valid_q && bus.out_ready && unord_q && (nan_cnt_q != 8'hFF))
      nan_cnt_d = nan_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) nan_cnt_q <= '0;
    else     nan_cnt_q <= nan_cnt_d;
  end

  assign bus.nan_cnt = nan_cnt_q;
`endif
endmodule

// File: tb/tb_fp_cmp_pipe.sv
// Self-checking bench for fp_cmp_pipe: ordering model over signed integer keys,
// directed vectors, backpressure, reset and (with FP_CMP_NAN_EN) NaN behaviour.
module tb_fp_cmp_pipe;
  localparam int EXP_W = 6;
  localparam int MAN_W = 9;
  localparam int W     = 1 + EXP_W + MAN_W;

  typedef struct {
    logic [W-1:0] res;
    logic lt, gt, eq, un;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic [W-1:0] res;
    logic lt, gt, eq, un;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp_cmp_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

  fp_cmp_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int fails  = 0;
  int n_out  = 0;
  int mcnt   = 0;
  exp_t q[$];
  vec_t vecs[$];

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit is_nan(logic [W-1:0] x);
    bit r = 1'b0;
`ifdef FP_CMP_NAN_EN
    logic [EXP_W-1:0] e = x[W-2:MAN_W];
    logic [MAN_W-1:0] m = x[MAN_W-1:0];
    r = (e == '1) && (m != '0);
`endif
    return r;
  endfunction

  // Real-line ordering: value key = +/- magnitude; -0 and +0 both map to 0
  function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    exp_t e;
    int ka, kb;
    bit an, bn, rel;
    an = is_nan(a);
    bn = is_nan(b);
    ka = a[W-1] ? -int'(a[W-2:0]) : int'(a[W-2:0]);
    kb = b[W-1] ? -int'(b[W-2:0]) : int'(b[W-2:0]);
    e.un = an || bn;
    e.lt = !e.un && (ka < kb);
    e.gt = !e.un && (ka > kb);
    e.eq = !e.un && (ka == kb);
    rel = 1'b0;
    e.res = '0;
    case (op)
      3'd0: rel = e.lt;
      3'd1: rel = e.gt;
      3'd2: rel = e.eq;
      3'd3: rel = e.lt || e.eq;
      3'd4: rel = e.gt || e.eq;
      default: rel = 1'b0;
    endcase
    if (op <= 3'd4) e.res = rel ? '1 : '0;
    else if (op == 3'd5) e.res = e.un ? ((an && !bn) ? b : a) : ((ka <= kb) ? a : b);
    else if (op == 3'd6) e.res = e.un ? ((an && !bn) ? b : a) : ((ka >= kb) ? a : b);
    return e;
  endfunction

  function automatic void addv(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op,
                               logic [W-1:0] res, logic lt, logic gt, logic eq, logic un);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.res = res;
    v.lt = lt; v.gt = gt; v.eq = eq; v.un = un;
    vecs.push_back(v);
  endfunction

  // Output monitor: sampled on the falling edge, away from the active edge
  bit           hold = 1'b0;
  logic [W-1:0] h_res;
  logic         h_lt, h_gt, h_eq, h_un;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      hold = 1'b0;
      mcnt = 0;
    end else begin
`ifdef FP_CMP_NAN_EN
      chk("nan_cnt_track", bus.nan_cnt, (mcnt > 255) ? 255 : mcnt);
`endif
      if (hold) begin
        chk("hold_valid", bus.out_valid, 1'b1);
        chk("hold_result", bus.result, h_res);
        chk("hold_flags", {bus.lt, bus.gt, bus.eq, bus.unord}, {h_lt, h_gt, h_eq, h_un});
      end
      hold = 1'b0;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          checks++;
          if (q.size() == 0) begin
            fails++;
            $display("FAIL spurious_out: got result 0x%h expected no output", bus.result);
          end else begin
            e = q.pop_front();
            chk("result", bus.result, e.res);
            chk("flags_lt_gt_eq_un", {bus.lt, bus.gt, bus.eq, bus.unord},
                {e.lt, e.gt, e.eq, e.un});
            if (e.un) mcnt++;
          end
          n_out++;
        end else begin
          hold  = 1'b1;
          h_res = bus.result;
          h_lt  = bus.lt; h_gt = bus.gt; h_eq = bus.eq; h_un = bus.unord;
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.a, bus.b, bus.opcode));
    end
  end

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
    bit acc = 1'b0;
    int n = 0;
    bus.a = a; bus.b = b; bus.opcode = op; bus.in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) begin
      checks++; fails++;
      $display("FAIL send_timeout: got no in_ready expected acceptance within 50 cycles");
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t m;
    int acc, idx, base, lat;
    bit done;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.opcode = 3'd0; bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.result, '0);
    chk("rst_flags", {bus.lt, bus.gt, bus.eq, bus.unord}, 4'b0);
`ifdef FP_CMP_NAN_EN
    chk("rst_nan_cnt", bus.nan_cnt, 8'd0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // Directed vectors with hand-computed expectations
    addv(16'h3E00, 16'h4000, 3'd0, 16'hFFFF, 1, 0, 0, 0);
    addv(16'hBE00, 16'hC000, 3'd6, 16'hBE00, 0, 1, 0, 0);
    addv(16'hBE00, 16'hC000, 3'd5, 16'hC000, 0, 1, 0, 0);
    addv(16'h0000, 16'h8000, 3'd2, 16'hFFFF, 0, 0, 1, 0);
    addv(16'h0000, 16'h8000, 3'd7, 16'h0000, 0, 0, 1, 0);
    addv(16'h3E00, 16'h4000, 3'd1, 16'h0000, 1, 0, 0, 0);
    addv(16'h4000, 16'h3E00, 3'd4, 16'hFFFF, 0, 1, 0, 0);
    addv(16'h3E00, 16'h3E00, 3'd3, 16'hFFFF, 0, 0, 1, 0);
    addv(16'h8000, 16'h3E00, 3'd3, 16'hFFFF, 1, 0, 0, 0);
    addv(16'h3E00, 16'hBE00, 3'd0, 16'h0000, 0, 1, 0, 0);
    addv(16'h3E00, 16'hBE00, 3'd5, 16'hBE00, 0, 1, 0, 0);
    addv(16'h4000, 16'h3E00, 3'd6, 16'h4000, 0, 1, 0, 0);
    addv(16'hC000, 16'h4000, 3'd2, 16'h0000, 1, 0, 0, 0);
    addv(16'h8001, 16'h0001, 3'd0, 16'hFFFF, 1, 0, 0, 0);
    addv(16'h8000, 16'h0000, 3'd4, 16'hFFFF, 0, 0, 1, 0);
`ifdef FP_CMP_NAN_EN
    addv(16'h7E01, 16'h3E00, 3'd4, 16'h0000, 0, 0, 0, 1);
    addv(16'h7E01, 16'h3E00, 3'd5, 16'h3E00, 0, 0, 0, 1);
    addv(16'h3E00, 16'h7E01, 3'd6, 16'h3E00, 0, 0, 0, 1);
    addv(16'h7E01, 16'h7E02, 3'd5, 16'h7E01, 0, 0, 0, 1);
    addv(16'h7E01, 16'h3E00, 3'd3, 16'h0000, 0, 0, 0, 1);
`else
    addv(16'h7E01, 16'h3E00, 3'd1, 16'hFFFF, 0, 1, 0, 0);
    addv(16'h7E01, 16'h7E02, 3'd5, 16'h7E01, 1, 0, 0, 0);
`endif
    foreach (vecs[i]) begin
      m = model(vecs[i].a, vecs[i].b, vecs[i].op);
      chk($sformatf("pin_res_%0d", i), m.res, vecs[i].res);
      chk($sformatf("pin_flags_%0d", i), {m.lt, m.gt, m.eq, m.un},
          {vecs[i].lt, vecs[i].gt, vecs[i].eq, vecs[i].un});
    end

    // Latency: out_valid appears in the second cycle after the input cycle
    bus.a = 16'h3E00; bus.b = 16'h4000; bus.opcode = 3'd0; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", bus.in_ready, 1'b1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 10);
    chk("latency", lat, 2);
    chk("lat_result", bus.result, 16'hFFFF);
    chk("lat_lt", bus.lt, 1'b1);
    @(posedge clk); #1;

    // Full-rate streaming of the directed table
    foreach (vecs[i]) begin
      bus.a = vecs[i].a; bus.b = vecs[i].b; bus.opcode = vecs[i].op; bus.in_valid = 1'b1;
      @(negedge clk);
      chk("stream_in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain();

    // Backpressure: 4 items, out_ready low for 5 cycles
    bus.out_ready = 1'b0;
    base = n_out;
    acc = 0;
    idx = 0;
    bus.in_valid = 1'b1;
    bus.a = vecs[0].a; bus.b = vecs[0].b; bus.opcode = vecs[0].op;
    repeat (5) begin
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk); #1;
      idx = acc;
      bus.a = vecs[idx].a; bus.b = vecs[idx].b; bus.opcode = vecs[idx].op;
    end
    chk("bp_accepted", acc, 2);
    chk("bp_in_ready_low", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("full_pass_in_ready", bus.in_ready, 1'b1);
    for (int n = 0; n < 20 && acc < 4; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk); #1;
      idx = acc;
      bus.a = vecs[idx].a; bus.b = vecs[idx].b; bus.opcode = vecs[idx].op;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("bp_out_count", n_out - base, 4);

    // Mixed random traffic with random backpressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [W-1:0] ra, rb;
          ra = W'($urandom);
          rb = (i % 5 == 0) ? ra : W'($urandom);
          if (i % 7 == 0) rb = {~ra[W-1], W'(0)} | (ra & {1'b0, {(W-1){1'b0}}});
          send(ra, rb, 3'($urandom_range(0, 7)));
        end
        done = 1'b1;
      end
      begin
        for (int n = 0; n < 2000 && !done; n++) begin
          @(posedge clk); #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

`ifdef FP_CMP_NAN_EN
    for (int i = 0; i < 300; i++) begin
      bus.a = 16'h7E01; bus.b = 16'h3E00; bus.opcode = 3'($urandom_range(0, 6));
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    drain();
    chk("nan_cnt_saturated", bus.nan_cnt, 8'd255);
`endif

    // Reset with two items in flight
    bus.out_ready = 1'b0;
    send(16'h3E00, 16'h4000, 3'd0);
    send(16'h4000, 16'h3E00, 3'd1);
    base = n_out;
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_result", bus.result, '0);
    chk("midrst_flags", {bus.lt, bus.gt, bus.eq, bus.unord}, 4'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_stale", n_out - base, 0);
`ifdef FP_CMP_NAN_EN
    chk("midrst_nan_cnt", bus.nan_cnt, 8'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end
endmodule

// File: doc/fp_cmp_pipe.md
FP_CMP_PIPE -- requirements
Module: fp_cmp_pipe

Interface
REQ-001 The block SHALL have parameter EXP_W, default 6, meaning exponent field width.
REQ-002 The block SHALL have parameter MAN_W, default 9, meaning mantissa field width; operand width W = 1+EXP_W+MAN_W (default 16, DLFloat16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-006 The block SHALL have ports a and b, input, W bits each: operands {sign, exp, mant}.
REQ-007 The block SHALL have port opcode, input, 3 bits: 000 LT, 001 GT, 010 EQ, 011 LE, 100 GE, 101 MIN, 110 MAX, 111 reserved.
REQ-008 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-009 The block SHALL have port result, output, W bits: all-ones/all-zeros flag for compare ops, or the selected operand for MIN/MAX.
REQ-010 The block SHALL have ports lt, gt, eq, output, 1 bit each: raw relation of the result's operand pair.
REQ-011 The block SHALL have port unord, output, 1 bit: the pair was unordered (NaN present; 0 when the macro is absent).

Function
REQ-012 Operands SHALL be compared sign-magnitude: different signs -> negative is smaller; same sign -> {exp,mant} compared unsigned, sense inverted when both are negative.
REQ-013 +0 and -0 (exp=0, mant=0, any sign) SHALL compare equal.
REQ-014 Exactly one of lt/gt/eq SHALL be 1 for an ordered pair; all three SHALL be 0 when unord=1.
REQ-015 LT/GT/EQ/LE/GE SHALL drive result = {W{relation}}; opcode 111 SHALL drive result = 0.
REQ-016 MIN SHALL return a if lt or eq, else b; MAX SHALL return a if gt or eq, else b.
REQ-017 The pipeline SHALL have two register stages (S1: field split, classification, magnitude compare; S2: op decode, result mux); latency is 2 cycles from an accepted input to out_valid with out_ready held high.
REQ-018 An input transfer occurs when in_valid and in_ready are both 1; an output transfer occurs when out_valid and out_ready are both 1.
REQ-019 S2 SHALL load when S2 is empty or out_ready=1; S1 SHALL load when S1 is empty or S2 loads; in_ready = S1 load condition (combinational from out_ready permitted).
REQ-020 Throughput SHALL be 1 transfer/cycle with out_ready=1; under out_ready=0 the block SHALL hold 2 items without loss or duplication, and result, lt, gt, eq, unord SHALL stay stable while out_valid=1 and out_ready=0.
REQ-021 A simultaneous input and output transfer on a full pipeline SHALL be accepted in the same cycle.

Reset
REQ-022 rst=1 SHALL asynchronously clear both stage valid bits; out_valid=0, result=0, lt=gt=eq=unord=0, nan_cnt=0.
REQ-023 Reset mid-operation SHALL discard in-flight items; in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-024 With macro FP_CMP_NAN_EN defined: exp all-ones and mant≠0 is NaN; any NaN operand sets unord=1, compare flags 0, LE/GE 0; MIN/MAX return the non-NaN operand (a if both NaN).
REQ-025 With FP_CMP_NAN_EN defined, the block SHALL provide output nan_cnt, 8 bits: saturating count of output transfers with unord=1, holding at 255.
REQ-026 Without FP_CMP_NAN_EN, NaN encodings SHALL be compared as ordinary magnitudes, unord SHALL be tied 0, and nan_cnt SHALL be absent.

Verification
REQ-027 a=0x3E00 (1.0), b=0x4000 (2.0), op LT, out_ready=1 -> out_valid 2 cycles later, result=0xFFFF, lt=1.
REQ-028 a=0xBE00 (-1.0), b=0xC000 (-2.0), op MAX -> result=0xBE00, gt=1; same operands with MIN -> result=0xC000.
REQ-029 a=0x0000, b=0x8000, op EQ -> result=0xFFFF, eq=1; opcode 111 -> result=0x0000.
REQ-030 Send 4 back-to-back items with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted; on out_ready=1 all 4 results emerge in order, none lost.
REQ-031 With FP_CMP_NAN_EN: a=0x7E01, b=0x3E00, op GE -> result=0, unord=1, nan_cnt increments; op MIN -> result=0x3E00; 300 NaN transfers -> nan_cnt=255.
REQ-032 Assert rst while 2 items are in flight -> out_valid=0 immediately, no stale result emerges after reset release.
